// File: rtl/shift_counter_pkg.sv
// rtl/shift_counter_pkg.sv - shared types, seeds and sequence lengths for shift_counter_mm
package shift_counter_pkg;

  typedef enum logic [1:0] {
    RING     = 2'b00,
    RING_N   = 2'b01,
    JOHNSON  = 2'b10,
    RESERVED = 2'b11
  } mode_t;

  // Bit i of the seed for mode m: RING 0..01, RING_N 1..10, JOHNSON and RESERVED all zeros
  function automatic logic seed(mode_t m, int i);
    case (m)
      RING:    return (i == 0);
      RING_N:  return (i != 0);
      default: return 1'b0;
    endcase
  endfunction

  // Number of distinct states in one full sequence of mode m for an n-bit register
  function automatic int seq_len(mode_t m, int n);
    return (m == JOHNSON) ? 2 * n : n;
  endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// rtl/shift_counter_decode.sv - combinational legality check and step-index decode
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  q,
  input  mode_t         mode_q,
  output logic [IW-1:0] idx,
  output logic          illegal
);

  int   ones;
  int   trans;
  int   pos1;
  int   pos0;
  int   idx_val;
  logic legal;

  // A Johnson state has at most one boundary between adjacent differing bits
  always_comb begin
    ones    = 0;
    trans   = 0;
    pos1    = 0;
    pos0    = 0;
    idx_val = 0;
    legal   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (q[i]) begin
        ones = ones + 1;
        pos1 = i;
      end else begin
        pos0 = i;
      end
    end
    for (int i = 0; i < N - 1; i++) begin
      if (q[i] != q[i+1]) trans = trans + 1;
    end
    case (mode_q)
      RING: begin
        legal   = (ones == 1);
        idx_val = pos1;
      end
      RING_N: begin
        legal   = (ones == N - 1);
        idx_val = pos0;
      end
      JOHNSON: begin
        legal   = (trans <= 1);
        idx_val = q[N-1] ? (N + (N - ones)) : ones;
      end
      default: begin
        legal   = 1'b0;
        idx_val = 0;
      end
    endcase
    illegal = ~legal;
    idx     = legal ? IW'(idx_val) : '0;
  end

endmodule

// File: rtl/shift_counter_mm.sv
// rtl/shift_counter_mm.sv - multi-mode ring / one-cold ring / Johnson counter
module shift_counter_mm
  import shift_counter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [IW-1:0] idx,
  output logic          illegal,
  output logic          wrap
);

  mode_t        mode_in;
  mode_t        mode_q;
  logic [N-1:0] seed_q;
  logic [N-1:0] step_q;
  logic [IW:0]  last_idx;
  logic         wrap_next;

  assign mode_in = mode_t'(mode);

  shift_counter_decode #(.N(N), .IW(IW)) u_decode (
    .q       (q),
    .mode_q  (mode_q),
    .idx     (idx),
    .illegal (illegal)
  );

  // Seed of the incoming mode; on every path that uses it mode equals mode_q or is about to
  always_comb begin
    seed_q = '0;
    for (int i = 0; i < N; i++) seed_q[i] = seed(mode_in, i);
  end

  // One rotation in the requested direction; Johnson inverts the bit that wraps around
  always_comb begin
    step_q = q;
    if (!dir) begin
      step_q = {q[N-2:0], (mode_q == JOHNSON) ? ~q[N-1] : q[N-1]};
    end else begin
      step_q = {(mode_q == JOHNSON) ? ~q[0] : q[0], q[N-1:1]};
    end
  end

  // Wrap fires when the step leaves the last state going up or the first state going down
  always_comb begin
    last_idx  = (IW + 1)'(seq_len(mode_q, N) - 1);
    wrap_next = dir ? (idx == '0) : ({1'b0, idx} == last_idx);
  end

  // State update in priority order: reset, mode change, load, self-correct, step, hold
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= mode_in;
      q      <= seed_q;
      wrap   <= 1'b0;
    end else if (mode_in != mode_q) begin
      mode_q <= mode_in;
      if (mode_in != RESERVED) q <= seed_q;
      wrap   <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      wrap <= 1'b0;
    end else if (en && mode_q != RESERVED && illegal) begin
      q    <= seed_q;
      wrap <= 1'b0;
    end else if (en && mode_q != RESERVED) begin
      q    <= step_q;
      wrap <= wrap_next;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_counter_mm.sv
// tb/tb_shift_counter_mm.sv - directed and randomized checks of shift_counter_mm against a sequence-table model
module tb_shift_counter_mm;

  localparam int N  = 4;
  localparam int IW = $clog2(2 * N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          load = 1'b0;
  logic [N-1:0]  load_val = '0;
  logic [N-1:0]  q;
  logic [IW-1:0] idx;
  logic          illegal;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  int       m_mode = 0;
  logic [3:0] m_q = 4'b0000;
  logic     m_wrap = 1'b0;

  shift_counter_mm #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .idx      (idx),
    .illegal  (illegal),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // k-th state of the sequence for a mode, built arithmetically
  function automatic logic [3:0] ref_state(int md, int k);
    case (md)
      0: return 4'(1 << k);
      1: return ~4'(1 << k);
      2: return (k <= N) ? 4'((1 << k) - 1) : 4'(~((1 << (k - N)) - 1));
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int ref_len(int md);
    return (md == 2) ? 2 * N : N;
  endfunction

  // Legal iff q appears in the mode's sequence table; idx is its position there
  task automatic ref_decode(input int md, input logic [3:0] v, output logic legal, output int k);
    legal = 1'b0;
    k = 0;
    if (md != 3) begin
      for (int j = 0; j < ref_len(md); j++) begin
        if (ref_state(md, j) == v) begin
          legal = 1'b1;
          k = j;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic d, input logic [1:0] md,
                     input logic l, input logic [3:0] lv);
    logic lg;
    int   k;
    int   len;
    rst = r; en = e; dir = d; mode = md; load = l; load_val = lv;
    @(posedge clk);
    if (r) begin
      m_mode = int'(md);
      m_q    = ref_state(m_mode, 0);
      m_wrap = 1'b0;
    end else if (int'(md) != m_mode) begin
      m_mode = int'(md);
      if (m_mode != 3) m_q = ref_state(m_mode, 0);
      m_wrap = 1'b0;
    end else if (l) begin
      m_q    = lv;
      m_wrap = 1'b0;
    end else if (e && m_mode != 3) begin
      ref_decode(m_mode, m_q, lg, k);
      len = ref_len(m_mode);
      if (!lg) begin
        m_q    = ref_state(m_mode, 0);
        m_wrap = 1'b0;
      end else begin
        m_wrap = d ? (k == 0) : (k == len - 1);
        m_q    = ref_state(m_mode, d ? (k + len - 1) % len : (k + 1) % len);
      end
    end else begin
      m_wrap = 1'b0;
    end
    #1;
    ref_decode(m_mode, m_q, lg, k);
    check("q", 32'(q), 32'(m_q));
    check("illegal", 32'(illegal), 32'(!lg));
    check("idx", 32'(idx), lg ? 32'(k) : 32'd0);
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  logic [3:0] jseq [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic [2:0] jidx [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  initial begin
    logic [1:0] rmd;
    logic       rr;

    // Johnson up-count through a full wrap
    cyc(1, 0, 0, 2'b10, 0, 4'b0);
    check("johnson_seed", 32'(q), 32'h0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 2'b10, 0, 4'b0);
      check("johnson_q", 32'(q), 32'(jseq[i]));
      check("johnson_idx", 32'(idx), 32'(jidx[i]));
      check("johnson_wrap", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
    end

    // Ring down-count wraps from the seed
    cyc(1, 0, 0, 2'b00, 0, 4'b0);
    check("ring_seed", 32'(q), 32'h1);
    cyc(0, 1, 1, 2'b00, 0, 4'b0);
    check("ring_down_q", 32'(q), 32'h8);
    check("ring_down_idx", 32'(idx), 32'd3);
    check("ring_down_wrap", 32'(wrap), 32'd1);
    cyc(0, 1, 1, 2'b00, 0, 4'b0);
    check("ring_down2_q", 32'(q), 32'h4);
    check("ring_down2_wrap", 32'(wrap), 32'd0);

    // Illegal load holds without en, then self-corrects
    cyc(0, 0, 0, 2'b00, 1, 4'b0110);
    check("load_illegal", 32'(illegal), 32'd1);
    check("load_idx", 32'(idx), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 2'b00, 0, 4'b0);
      check("illegal_hold_q", 32'(q), 32'h6);
    end
    cyc(0, 1, 0, 2'b00, 0, 4'b0);
    check("correct_q", 32'(q), 32'h1);
    check("correct_wrap", 32'(wrap), 32'd0);

    // Mode change beats load and en
    cyc(1, 0, 0, 2'b01, 0, 4'b0);
    cyc(0, 1, 0, 2'b01, 0, 4'b0);
    check("ringn_q", 32'(q), 32'hd);
    cyc(0, 1, 0, 2'b10, 1, 4'b1011);
    check("modechg_q", 32'(q), 32'h0);

    // Reserved mode freezes q
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 2'b11, 0, 4'b0);
      check("reserved_q", 32'(q), 32'h0);
      check("reserved_illegal", 32'(illegal), 32'd1);
    end
    cyc(0, 0, 0, 2'b00, 0, 4'b0);
    check("leave_reserved_q", 32'(q), 32'h1);

    // Reset beats en; load beats en
    cyc(1, 0, 0, 2'b10, 0, 4'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2'b10, 0, 4'b0);
    check("johnson_0111", 32'(q), 32'h7);
    cyc(1, 1, 0, 2'b10, 0, 4'b0);
    check("rst_en_q", 32'(q), 32'h0);
    check("rst_en_wrap", 32'(wrap), 32'd0);
    cyc(0, 1, 0, 2'b10, 1, 4'b1100);
    check("load_en_q", 32'(q), 32'hc);
    check("load_en_idx", 32'(idx), 32'd6);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rr  = ($urandom_range(0, 39) == 0);
      rmd = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_mode);
      cyc(rr, 1'($urandom_range(0, 3) != 0), 1'($urandom), rmd,
          ($urandom_range(0, 9) == 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
